// File: rtl/rv_mem_pkg.sv
// Shared definitions for the memory stage: RV load/store funct3 encodings,
// the access FSM states and default datapath widths.
package rv_mem_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int MAT_W_DEF = 128;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, SCALAR, MAT, DONE} state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for scalar accesses: load lane select with sign/zero
// extension, store data replication and byte-strobe generation.
module mem_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_data,
  output logic [3:0]  o_wstrb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[8*i_addr_lo +: 8];
  assign w_half = i_rdata[16*i_addr_lo[1] +: 16];

  always_comb begin
    o_load_data  = i_rdata;
    o_store_data = i_wdata;
    o_wstrb      = 4'hF;
    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_load_data = {24'd0, w_byte};
      F3_LHU:  o_load_data = {16'd0, w_half};
      F3_LW:   o_load_data = i_rdata;
      default: o_load_data = i_rdata;
    endcase
    // Misaligned halves/words simply drop the low address bits.
    case ({1'b0, i_funct3[1:0]})
      F3_SB: begin
        o_store_data = {4{i_wdata[7:0]}};
        o_wstrb      = 4'b0001 << i_addr_lo;
      end
      F3_SH: begin
        o_store_data = {2{i_wdata[15:0]}};
        o_wstrb      = 4'b0011 << {i_addr_lo[1], 1'b0};
      end
      F3_SW:   o_wstrb = 4'hF;
      default: o_wstrb = 4'hF;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory pipeline stage: scalar loads/stores and multi-beat matrix-row
// accesses over one 32-bit data port, feeding the MEM/WB register.
module stage_mem
  import rv_mem_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int MAT_W = MAT_W_DEF,
  parameter int BEATS = MAT_W / XLEN
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_alu_o,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [MAT_W-1:0] ex_matrix_data,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_mat_load,
  input  logic             ex_mat_store,
  input  logic             ex_mem2reg,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [3:0]       dmem_wstrb,
  output logic             dmem_re,
  output logic             dmem_we,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_ready,
  output logic             mem_stall,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_mem_data,
  output logic [XLEN-1:0]  wb_alu_o,
  output logic [MAT_W-1:0] wb_matrix_o,
  output logic             wb_mem2reg
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t           r_state;
  logic [BW-1:0]    r_beat;
  logic [MAT_W-1:0] r_row;
  logic             r_wb_valid, r_wb_mem2reg;
  logic [XLEN-1:0]  r_wb_mem_data, r_wb_alu;
  logic [MAT_W-1:0] r_wb_matrix;

  logic            w_idle, w_mat_op, w_scal_op, w_mat_act, w_sc_act;
  logic            w_last, w_stall, w_wb_load;
  logic [BW-1:0]   w_beat;
  logic [XLEN-1:0] w_base, w_ld_data, w_st_data;
  logic [3:0]      w_st_strb;

  mem_align u_align (
    .i_funct3     (ex_funct3),
    .i_addr_lo    (ex_alu_o[1:0]),
    .i_rdata      (dmem_rdata),
    .i_wdata      (ex_rs2_data),
    .o_load_data  (w_ld_data),
    .o_store_data (w_st_data),
    .o_wstrb      (w_st_strb)
  );

  // Beat 0 of a matrix access and every scalar access issue straight from IDLE.
  assign w_idle    = (r_state == IDLE);
  assign w_mat_op  = ex_valid & (ex_mat_load | ex_mat_store);
  assign w_scal_op = ex_valid & ~(ex_mat_load | ex_mat_store) & (ex_mem_read | ex_mem_write);
  assign w_mat_act = (w_idle & w_mat_op) | (r_state == MAT);
  assign w_sc_act  = (w_idle & w_scal_op) | (r_state == SCALAR);
  assign w_beat    = (r_state == MAT) ? r_beat : '0;
  assign w_last    = dmem_ready & (w_beat == BW'(BEATS - 1));
  assign w_base    = {ex_alu_o[XLEN-1:4], 4'b0000};
  assign w_stall   = w_mat_act | (w_sc_act & ~dmem_ready);
  assign w_wb_load = (w_idle & ex_valid & ~w_mat_op & ~w_scal_op)
                   | (w_sc_act & dmem_ready) | (r_state == DONE);

  assign mem_stall = ~rst & w_stall;
  assign dmem_re   = ~rst & (w_mat_act ? ex_mat_load : (w_sc_act & ex_mem_read));
  assign dmem_we   = ~rst & (w_mat_act ? ~ex_mat_load : (w_sc_act & ~ex_mem_read));

  always_comb begin
    dmem_addr  = {ex_alu_o[XLEN-1:2], 2'b00};
    dmem_wdata = w_st_data;
    dmem_wstrb = 4'b0000;
    if (w_mat_act) begin
      dmem_addr  = w_base + (XLEN'(w_beat) << 2);
      dmem_wdata = ex_matrix_data[XLEN*w_beat +: XLEN];
      if (!ex_mat_load) dmem_wstrb = 4'hF;
    end else if (w_sc_act && !ex_mem_read) begin
      dmem_wstrb = w_st_strb;
    end
    if (rst) dmem_wstrb = 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_beat        <= '0;
      r_row         <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_mem_data <= '0;
      r_wb_alu      <= '0;
      r_wb_matrix   <= '0;
      r_wb_mem2reg  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mat_op) begin
            r_state <= MAT;
            r_beat  <= dmem_ready ? BW'(1) : '0;
          end else if (w_scal_op && !dmem_ready) begin
            r_state <= SCALAR;
          end
        end
        SCALAR: if (dmem_ready) r_state <= IDLE;
        MAT: begin
          if (w_last) begin
            r_state <= DONE;
            r_beat  <= '0;
          end else if (dmem_ready) begin
            r_beat <= r_beat + BW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_mat_act && ex_mat_load && dmem_ready)
        r_row[XLEN*w_beat +: XLEN] <= dmem_rdata;

      // MEM/WB register; stalled cycles become bubbles.
      if (w_wb_load) begin
        r_wb_valid    <= 1'b1;
        r_wb_alu      <= ex_alu_o;
        r_wb_mem2reg  <= ex_mem2reg;
        r_wb_mem_data <= (w_sc_act && ex_mem_read) ? w_ld_data : '0;
        r_wb_matrix   <= ((r_state == DONE) && ex_mat_load) ? r_row : ex_matrix_data;
      end else begin
        r_wb_valid <= 1'b0;
        if (w_stall) r_wb_mem2reg <= 1'b0;
      end
    end
  end

  assign wb_valid    = r_wb_valid;
  assign wb_mem_data = r_wb_mem_data;
  assign wb_alu_o    = r_wb_alu;
  assign wb_matrix_o = r_wb_matrix;
  assign wb_mem2reg  = r_wb_mem2reg;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem with a latency-programmable data memory.
module tb_stage_mem;
  import rv_mem_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ex_valid = 1'b0;
  logic [31:0]  ex_alu_o = '0, ex_rs2_data = '0;
  logic [127:0] ex_matrix_data = '0;
  logic [2:0]   ex_funct3 = '0;
  logic         ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic         ex_mat_load = 1'b0, ex_mat_store = 1'b0, ex_mem2reg = 1'b0;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]   dmem_wstrb;
  logic         dmem_re, dmem_we, dmem_ready, mem_stall;
  logic         wb_valid, wb_mem2reg;
  logic [31:0]  wb_mem_data, wb_alu_o;
  logic [127:0] wb_matrix_o;

  stage_mem dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_o(ex_alu_o),
    .ex_rs2_data(ex_rs2_data), .ex_matrix_data(ex_matrix_data), .ex_funct3(ex_funct3),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mat_load(ex_mat_load),
    .ex_mat_store(ex_mat_store), .ex_mem2reg(ex_mem2reg), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_mem_data(wb_mem_data), .wb_alu_o(wb_alu_o),
    .wb_matrix_o(wb_matrix_o), .wb_mem2reg(wb_mem2reg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  md;
    logic [31:0]  alu;
    logic [127:0] mat;
    logic         m2r;
  } wbx_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        we;
  } txn_t;

  wbx_t        sb[$];
  txn_t        log_q[$];
  wbx_t        e_mon;
  logic [31:0] mem [0:4095];
  int          lat = 0, wcnt = 0;
  int          n_chk = 0, n_err = 0, n_pulse = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Data memory: ready after `lat` wait cycles per request.
  assign dmem_ready = (dmem_re || dmem_we) && (wcnt == lat);
  assign dmem_rdata = mem[dmem_addr[13:2]];

  always @(posedge clk) begin
    if (dmem_re || dmem_we) begin
      if (dmem_ready) begin
        log_q.push_back('{dmem_addr, dmem_wdata, dmem_wstrb, dmem_we});
        if (dmem_we)
          for (int b = 0; b < 4; b++)
            if (dmem_wstrb[b]) mem[dmem_addr[13:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
        wcnt = 0;
      end else begin
        wcnt = wcnt + 1;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      n_pulse++;
      if (sb.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        e_mon = sb.pop_front();
        chk("wb_mem_data", wb_mem_data, e_mon.md);
        chk("wb_alu_o", wb_alu_o, e_mon.alu);
        chk("wb_matrix_o", wb_matrix_o, e_mon.mat);
        chk("wb_mem2reg", wb_mem2reg, e_mon.m2r);
      end
    end
    if (dmem_re && dmem_we) chk("re_we_exclusive", 1, 0);
  end

  // ops = {mat_load, mat_store, mem_read, mem_write}
  task automatic issue(input logic [3:0] ops, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [127:0] md, input logic [2:0] f3, input logic m2r,
                       input int l, input logic [31:0] exp_md, input logic [127:0] exp_mat,
                       output int stalls);
    logic st, ok;
    @(posedge clk); #1;
    log_q.delete();
    lat = l;
    ex_valid = 1'b1; ex_alu_o = alu; ex_rs2_data = rs2; ex_matrix_data = md;
    ex_funct3 = f3; ex_mem2reg = m2r;
    {ex_mat_load, ex_mat_store, ex_mem_read, ex_mem_write} = ops;
    sb.push_back('{exp_md, alu, exp_mat, m2r});
    stalls = 0; ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      st = mem_stall;
      if (st) stalls++;
      @(posedge clk);
      if (!st) begin ok = 1'b1; break; end
    end
    #1;
    ex_valid = 1'b0;
    {ex_mat_load, ex_mat_store, ex_mem_read, ex_mem_write} = 4'b0000;
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      @(negedge clk);
      chk("wb_valid_after_accept", wb_valid, 1);
    end
    #1;
  endtask

  task automatic chk_txn(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic we);
    if (i >= log_q.size()) chk("txn_missing", 0, 1);
    else begin
      chk("txn_addr", log_q[i].a, a);
      if (we) chk("txn_wdata", log_q[i].d, d);
      chk("txn_wstrb", log_q[i].s, s);
      chk("txn_we", log_q[i].we, we);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stl, p0;
    logic [127:0] md, row;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_mem_data", wb_mem_data, 0);
    chk("rst_wb_alu_o", wb_alu_o, 0);
    chk("rst_wb_matrix_o", wb_matrix_o, 0);
    chk("rst_wb_mem2reg", wb_mem2reg, 0);
    chk("rst_dmem_re", dmem_re, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_wstrb", dmem_wstrb, 0);
    chk("rst_mem_stall", mem_stall, 0);

    md = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    mem[12'h040] = 32'hDEADBEEF;
    issue(4'b0010, 32'h100, 0, md, F3_LW, 1, 0, 32'hDEADBEEF, md, stl);
    chk("lw_no_stall", stl, 0);
    chk("lw_addr", log_q.size() > 0 ? log_q[0].a : 32'hX, 32'h100);

    mem[12'h040] = 32'h80AABBCC;
    issue(4'b0010, 32'h103, 0, md, F3_LB, 1, 0, 32'hFFFFFF80, md, stl);
    issue(4'b0010, 32'h103, 0, md, F3_LBU, 1, 0, 32'h00000080, md, stl);
    issue(4'b0010, 32'h102, 0, md, F3_LH, 1, 0, 32'hFFFF80AA, md, stl);
    issue(4'b0010, 32'h101, 0, md, F3_LHU, 1, 0, 32'h0000BBCC, md, stl);

    mem[12'h041] = 32'h76543210;
    issue(4'b0010, 32'h106, 0, md, F3_LW, 1, 2, 32'h76543210, md, stl);
    chk("lw_wait2_stalls", stl, 2);

    issue(4'b0001, 32'h202, 32'h00001234, md, F3_SH, 0, 0, 0, md, stl);
    chk("sh_no_stall", stl, 0);
    chk("sh_txn_count", log_q.size(), 1);
    chk_txn(0, 32'h200, 32'h12341234, 4'b1100, 1);
    chk("sh_mem", mem[12'h080], 32'h12340000);

    issue(4'b0001, 32'h301, 32'hFFFFFFAB, md, F3_SB, 0, 1, 0, md, stl);
    chk("sb_stalls", stl, 1);
    chk_txn(0, 32'h300, 32'hABABABAB, 4'b0010, 1);
    chk("sb_mem", mem[12'h0C0], 32'h0000AB00);

    issue(4'b0000, 32'h55, 0, ~md, F3_LW, 0, 0, 0, ~md, stl);
    chk("alu_no_stall", stl, 0);

    for (int i = 0; i < 4; i++) mem[12'h400 + i] = 32'h11 * (i + 1);
    row = 128'h00000044_00000033_00000022_00000011;
    p0 = n_pulse;
    issue(4'b1000, 32'h1000, 0, md, F3_LW, 0, 1, 0, row, stl);
    chk("mload_stalls", stl, 8);
    chk("mload_pulses", n_pulse - p0, 1);
    chk("mload_txn_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_txn(i, 32'h1000 + 4 * i, 0, 4'b0000, 0);

    md = 128'hA3A3A3A3_B2B2B2B2_C1C1C1C1_D0D0D0D0;
    issue(4'b0100, 32'h2008, 0, md, F3_SW, 0, 0, 0, md, stl);
    chk("mstore_stalls", stl, 4);
    chk("mstore_txn_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_txn(i, 32'h2000 + 4 * i, md[32*i +: 32], 4'hF, 1);
    chk("mstore_mem1", mem[12'h801], 32'hC1C1C1C1);

    // Reset in the middle of a matrix load.
    @(posedge clk); #1;
    lat = 1;
    ex_valid = 1'b1; ex_mat_load = 1'b1; ex_alu_o = 32'h3000; ex_mem2reg = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (dmem_re && dmem_addr == 32'h3008) begin seen = 1'b1; break; end
      end
      chk("abort_beat2_seen", seen, 1);
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_dmem_re", dmem_re, 0);
    chk("abort_mem_stall", mem_stall, 0);
    chk("abort_wb_valid", wb_valid, 0);
    chk("abort_wb_alu_o", wb_alu_o, 0);
    chk("abort_wb_matrix_o", wb_matrix_o, 0);
    ex_valid = 1'b0; ex_mat_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    mem[12'h042] = 32'hCAFEF00D;
    issue(4'b0010, 32'h108, 0, md, F3_LW, 1, 0, 32'hCAFEF00D, md, stl);
    chk("post_rst_no_stall", stl, 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
